// File: rtl/decade_pkg.sv
// Shared types and helpers for the BCD countdown timer and its digit cells.
package decade_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } cd_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Out-of-range BCD nibbles saturate to 9 rather than wrapping.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/decade_down_digit.sv
// One BCD digit that counts down 9..0 and wraps, with synchronous load.
module decade_down_digit
    import decade_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       bin,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       bout
);

    logic step;

    assign step = en & bin;
    // Borrow-out is combinational so the next digit steps on the same edge.
    assign bout = step & (q == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 4'd0;
        end else if (ld) begin
            q <= ld_val;
        end else if (step) begin
            q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with prescaler, pause/resume and terminal-count pulses.
// Optional AUTO_RELOAD_EN: keep running at 00 and reload the stored value on the next decrement.
module bcd_countdown_timer
    import decade_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    input  logic       tick,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       borrow,
    output logic       zero,
    output logic       done
);

    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    cd_state_t  state;
    logic [7:0] presc;
    logic       run_tick, presc_wrap, dec;
    logic       ones_bout, tens_bout;
    logic       reaches_zero, borrow_nx;
    logic       digit_ld;
    logic [3:0] ld_tens_val, ld_ones_val;

    // A tick only counts in RUN when nothing of higher priority is present.
    assign run_tick     = (state == RUN) & tick & ~pause & ~load;
    assign presc_wrap   = (presc == PRESC_LAST);
    assign dec          = run_tick & presc_wrap;
    assign reaches_zero = dec & (tens == 4'd0) & (ones == 4'd1);
    // Both digits borrowing at once means a decrement from 00 (reload), not a wrap.
    assign borrow_nx    = ones_bout & ~tens_bout;

`ifdef AUTO_RELOAD_EN
    logic [3:0] rl_tens, rl_ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            rl_tens <= 4'd0;
            rl_ones <= 4'd0;
        end else if (load) begin
            rl_tens <= bcd_clamp(load_tens);
            rl_ones <= bcd_clamp(load_ones);
        end
    end

    assign digit_ld    = load | tens_bout;
    assign ld_tens_val = load ? bcd_clamp(load_tens) : rl_tens;
    assign ld_ones_val = load ? bcd_clamp(load_ones) : rl_ones;
`else
    assign digit_ld    = load;
    assign ld_tens_val = bcd_clamp(load_tens);
    assign ld_ones_val = bcd_clamp(load_ones);
`endif

    decade_down_digit u_ones (
        .clk    (clk),
        .rst    (rst),
        .en     (run_tick),
        .bin    (presc_wrap),
        .ld     (digit_ld),
        .ld_val (ld_ones_val),
        .q      (ones),
        .bout   (ones_bout)
    );

    decade_down_digit u_tens (
        .clk    (clk),
        .rst    (rst),
        .en     (ones_bout),
        .bin    (1'b1),
        .ld     (digit_ld),
        .ld_val (ld_tens_val),
        .q      (tens),
        .bout   (tens_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            presc   <= 8'd0;
            running <= 1'b0;
            borrow  <= 1'b0;
            zero    <= 1'b0;
            done    <= 1'b0;
        end else begin
            borrow <= borrow_nx;
            zero   <= reaches_zero;
            if (load) begin
                state   <= IDLE;
                presc   <= 8'd0;
                running <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if ((tens != 4'd0) || (ones != 4'd0)) begin
                                state   <= RUN;
                                running <= 1'b1;
                                presc   <= 8'd0;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            if (presc_wrap) begin
                                presc <= 8'd0;
`ifndef AUTO_RELOAD_EN
                                if (reaches_zero) begin
                                    state   <= DONE;
                                    running <= 1'b0;
                                    done    <= 1'b1;
                                end
`endif
                            end else begin
                                presc <= presc + 8'd1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (start && !pause) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: two instances (PRESCALE 1 and 4) against a decimal-count model.
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] load_tens, load_ones;
    logic       start, pause, tick;

    logic [3:0] a_tens, a_ones, b_tens, b_ones;
    logic       a_running, a_borrow, a_zero, a_done;
    logic       b_running, b_borrow, b_zero, b_done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    bcd_countdown_timer #(.PRESCALE(1)) u_a (
        .clk(clk), .rst(rst), .load(load), .load_tens(load_tens), .load_ones(load_ones),
        .start(start), .pause(pause), .tick(tick),
        .tens(a_tens), .ones(a_ones), .running(a_running), .borrow(a_borrow),
        .zero(a_zero), .done(a_done)
    );

    bcd_countdown_timer #(.PRESCALE(4)) u_b (
        .clk(clk), .rst(rst), .load(load), .load_tens(load_tens), .load_ones(load_ones),
        .start(start), .pause(pause), .tick(tick),
        .tens(b_tens), .ones(b_ones), .running(b_running), .borrow(b_borrow),
        .zero(b_zero), .done(b_done)
    );

    // Model: the count is a plain integer 0..99; digits are derived with / and %.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_count[2], m_mode[2], m_presc[2], m_reload[2];
    bit m_borrow[2], m_zero[2];
    bit model_ok = 1'b0;

    function automatic int ps_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int clamp9(input logic [3:0] v);
        return (v > 4'd9) ? 9 : int'(v);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_borrow[i] = 1'b0;
            m_zero[i]   = 1'b0;
            if (rst) begin
                m_count[i] = 0; m_mode[i] = M_IDLE; m_presc[i] = 0; m_reload[i] = 0;
            end else if (load) begin
                m_count[i]  = clamp9(load_tens) * 10 + clamp9(load_ones);
                m_reload[i] = m_count[i];
                m_presc[i]  = 0;
                m_mode[i]   = M_IDLE;
            end else begin
                case (m_mode[i])
                    M_IDLE: if (start) begin
                        m_presc[i] = 0;
                        m_mode[i]  = (m_count[i] != 0) ? M_RUN : M_DONE;
                    end
                    M_RUN: begin
                        if (pause) m_mode[i] = M_PAUSE;
                        else if (tick) begin
                            if (m_presc[i] == ps_of(i) - 1) begin
                                m_presc[i] = 0;
                                if (m_count[i] == 0) begin
                                    m_count[i] = m_reload[i];
                                end else begin
                                    if (m_count[i] % 10 == 0) m_borrow[i] = 1'b1;
                                    m_count[i] = m_count[i] - 1;
                                    if (m_count[i] == 0) begin
                                        m_zero[i] = 1'b1;
`ifndef AUTO_RELOAD_EN
                                        m_mode[i] = M_DONE;
`endif
                                    end
                                end
                            end else begin
                                m_presc[i] = m_presc[i] + 1;
                            end
                        end
                    end
                    M_PAUSE: if (start && !pause) m_mode[i] = M_RUN;
                    default: ;
                endcase
            end
        end
        model_ok = 1'b1;
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input int i, input logic [3:0] t, input logic [3:0] o,
                            input logic r, input logic b, input logic z, input logic d);
        chk({tag, "_tens"},    8'(t), 8'(m_count[i] / 10));
        chk({tag, "_ones"},    8'(o), 8'(m_count[i] % 10));
        chk({tag, "_running"}, 8'(r), 8'(m_mode[i] == M_RUN));
        chk({tag, "_borrow"},  8'(b), 8'(m_borrow[i]));
        chk({tag, "_zero"},    8'(z), 8'(m_zero[i]));
        chk({tag, "_done"},    8'(d), 8'(m_mode[i] == M_DONE));
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            cmp_inst("a", 0, a_tens, a_ones, a_running, a_borrow, a_zero, a_done);
            cmp_inst("b", 1, b_tens, b_ones, b_running, b_borrow, b_zero, b_done);
        end
    end

    task automatic cyc(input bit l, input logic [3:0] lt, input logic [3:0] lo,
                       input bit s, input bit p, input bit t);
        load = l; load_tens = lt; load_ones = lo; start = s; pause = p; tick = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; load_tens = 4'd7; load_ones = 4'd3;
        start = 1'b1; pause = 1'b0; tick = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lit_rst_count", {a_tens, a_ones}, 8'h00);
        chk("lit_rst_flags", {4'd0, a_running, a_done, a_borrow, a_zero}, 8'h00);
        chk("lit_rst_b_flags", {4'd0, b_running, b_done, b_borrow, b_zero}, 8'h00);
        rst = 1'b0;

        // Clamp of out-of-range nibbles
        cyc(1'b1, 4'hC, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("lit_clamp_a", {a_tens, a_ones}, 8'h99);
        chk("lit_clamp_b", {b_tens, b_ones}, 8'h99);

        // Basic count from 12
        cyc(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("lit_started", 8'(a_running), 8'd1);
        exp_q.push_back(8'h11); exp_q.push_back(8'h10); exp_q.push_back(8'h09);
        for (int k = 0; k < 3; k++) begin
            ticks(1);
            chk("lit_basic_count", {a_tens, a_ones}, exp_q.pop_front());
        end
        chk("lit_borrow_pulse", 8'(a_borrow), 8'd1);
        ticks(9);
        chk("lit_reach_zero", {a_tens, a_ones}, 8'h00);
        chk("lit_zero_pulse", 8'(a_zero), 8'd1);
`ifndef AUTO_RELOAD_EN
        chk("lit_done_level", {6'd0, a_done, a_running}, 8'b10);
        ticks(2);
        chk("lit_hold_zero", {a_tens, a_ones}, 8'h00);
        chk("lit_zero_once", 8'(a_zero), 8'd0);
`endif

        // Prescaler on the PRESCALE=4 instance
        cyc(1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        ticks(8);
        chk("lit_presc_03", {b_tens, b_ones}, 8'h03);
        ticks(2);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("lit_paused", 8'(b_running), 8'd0);
        ticks(5);
        chk("lit_pause_hold", {b_tens, b_ones}, 8'h03);
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        ticks(2);
        chk("lit_resume_02", {b_tens, b_ones}, 8'h02);

        // Priority: load beats tick, pause beats start
        cyc(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        chk("lit_29", {a_tens, a_ones}, 8'h29);
        cyc(1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("lit_load_wins", {a_tens, a_ones}, 8'h50);
        chk("lit_load_idle", 8'(a_running), 8'd0);
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1);
        chk("lit_pause_wins", {6'd0, a_running, a_done}, 8'd0);
        ticks(1);
        chk("lit_pause_count", {a_tens, a_ones}, 8'h50);

        // Load 00 then start: straight to DONE with no zero pulse
        cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("lit_00_done", {5'd0, a_done, a_zero, a_running}, 8'b100);

        // Reset in the middle of a borrow pulse
        cyc(1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        chk("lit_19_borrow", {3'd0, a_borrow, a_ones}, 8'h19);
        rst = 1'b1;
        ticks(1);
        chk("lit_midrst", {a_tens, a_ones}, 8'h00);
        chk("lit_midrst_flags", {4'd0, a_running, a_done, a_borrow, a_zero}, 8'h00);
        rst = 1'b0;

`ifdef AUTO_RELOAD_EN
        cyc(1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        chk("lit_ar_01", {a_tens, a_ones}, 8'h01);
        ticks(1);
        chk("lit_ar_00", {a_tens, a_ones}, 8'h00);
        chk("lit_ar_flags", {5'd0, a_zero, a_running, a_done}, 8'b110);
        ticks(1);
        chk("lit_ar_reload", {a_tens, a_ones}, 8'h02);
        chk("lit_ar_noborrow", 8'(a_borrow), 8'd0);
`endif

        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
